// File: rtl/mem_responder.sv
// Multi-cycle memory responder: one request at a time, fixed wait, one-cycle ready pulse.
// Word-organised little-endian store with byte/half write merging and alignment checking.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; latches the request and checks alignment
// WAIT  | counting down LATENCY cycles; access performed when count is 0
// DONE  | ready pulse (err reported here for illegal requests)
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic              illegal;
  logic              do_access;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       merged;
  logic [31:0]       mem [DEPTH];

  // Address bits above the store size alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign illegal = (size == 2'b11) ||
                   ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b00) && (addr[1:0] != 2'b00));

  assign idx_q     = addr_q[ADDR_W+1:2];
  assign do_access = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = illegal ? DONE : WAIT;
      WAIT: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    err   = 1'b0;
    case (state)
      WAIT: busy = 1'b1;
      DONE: begin
        ready = 1'b1;
        busy  = 1'b1;
        err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && req) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
        err_q   <= illegal;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (do_access && !wr_q) rdata <= mem[idx_q];
    end
  end

  // Lanes outside the written field keep their stored value.
  always_comb begin
    merged = mem[idx_q];
    case (size_q)
      2'b00: merged = wdata_q;
      2'b01: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      2'b10: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_access && wr_q) begin
      mem[idx_q] <= merged;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_W=8, LATENCY=3).
module tb_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Issues one request and watches LAT+3 cycles after acceptance.
  // rk = first cycle (1 = between E and E+1) with ready high.
  task automatic do_access(input logic w, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] d, output int rk, output int rcnt,
                           output int bcnt, output logic e_at_r, output logic e_bad);
    @(negedge clk);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    rk = -1; rcnt = 0; bcnt = 0; e_at_r = 1'b0; e_bad = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        rcnt++;
        if (rk < 0) begin
          rk = k;
          e_at_r = err;
        end
      end else if (err !== 1'b0) begin
        e_bad = 1'b1;
      end
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (busy  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err   !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    int rk, rc, bc; logic ea, eb;
    do_access(1'b0, 2'b00, 32'h10, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rk !== LAT + 1) begin bad++; $display("FAIL rd_ready_cycle got=%0d exp=%0d", rk, LAT + 1); end
    total++; if (rc !== 1) begin bad++; $display("FAIL rd_ready_count got=%0d exp=1", rc); end
    total++; if (bc !== LAT + 1) begin bad++; $display("FAIL rd_busy_cycles got=%0d exp=%0d", bc, LAT + 1); end
    total++; if (ea !== 1'b0 || eb !== 1'b0) begin bad++; $display("FAIL rd_err got=%b/%b exp=0/0", ea, eb); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rd_rdata got=%h exp=00000000", rdata); end
  endtask

  task automatic test_write_read();
    int rk, rc, bc; logic ea, eb;
    do_access(1'b1, 2'b00, 32'h20, 32'hDEADBEEF, rk, rc, bc, ea, eb);
    total++; if (rk !== LAT + 1 || ea !== 1'b0) begin bad++; $display("FAIL wr_word_done got=%0d/%b exp=%0d/0", rk, ea, LAT + 1); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL wr_keeps_rdata got=%h exp=00000000", rdata); end
    do_access(1'b0, 2'b00, 32'h20, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_word got=%h exp=deadbeef", rdata); end
    do_access(1'b0, 2'b00, 32'h0, 32'h0, rk, rc, bc, ea, eb);
    do_access(1'b0, 2'b00, 32'h420, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_alias got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_partial();
    int rk, rc, bc; logic ea, eb;
    do_access(1'b1, 2'b10, 32'h21, 32'hFFFFFFAA, rk, rc, bc, ea, eb);
    total++; if (rk !== LAT + 1 || ea !== 1'b0) begin bad++; $display("FAIL wr_byte_done got=%0d/%b exp=%0d/0", rk, ea, LAT + 1); end
    do_access(1'b0, 2'b10, 32'h23, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'hDEADAAEF) begin bad++; $display("FAIL rd_after_byte got=%h exp=deadaaef", rdata); end
    do_access(1'b1, 2'b01, 32'h22, 32'hFFFF1234, rk, rc, bc, ea, eb);
    total++; if (rk !== LAT + 1 || ea !== 1'b0) begin bad++; $display("FAIL wr_half_done got=%0d/%b exp=%0d/0", rk, ea, LAT + 1); end
    do_access(1'b0, 2'b00, 32'h20, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'h1234AAEF) begin bad++; $display("FAIL rd_after_half got=%h exp=1234aaef", rdata); end
  endtask

  task automatic test_errors();
    int rk, rc, bc; logic ea, eb;
    logic        vw [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  vs [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
    logic [31:0] va [4] = '{32'h23, 32'h21, 32'h20, 32'h22};
    for (int i = 0; i < 4; i++) begin
      do_access(vw[i], vs[i], va[i], 32'hFFFFFFFF, rk, rc, bc, ea, eb);
      total++; if (rk !== 1 || rc !== 1) begin bad++; $display("FAIL err%0d_ready got=cyc%0d/n%0d exp=cyc1/n1", i, rk, rc); end
      total++; if (ea !== 1'b1 || eb !== 1'b0) begin bad++; $display("FAIL err%0d_flag got=%b/%b exp=1/0", i, ea, eb); end
      total++; if (bc !== 1) begin bad++; $display("FAIL err%0d_busy got=%0d exp=1", i, bc); end
      total++; if (rdata !== 32'h1234AAEF) begin bad++; $display("FAIL err%0d_rdata got=%h exp=1234aaef", i, rdata); end
    end
    do_access(1'b0, 2'b00, 32'h20, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'h1234AAEF) begin bad++; $display("FAIL err_store_intact got=%h exp=1234aaef", rdata); end
  endtask

  task automatic test_back_to_back();
    int rcnt = 0, idle_cnt = 0, misplaced = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h20;
    @(posedge clk);
    for (int k = 1; k <= 5 * (LAT + 2); k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        rcnt++;
        if ((k - (LAT + 1)) % (LAT + 2) != 0) misplaced++;
      end
      if (busy === 1'b0) idle_cnt++;
      if (k == 5 * (LAT + 2)) req = 1'b0;
    end
    total++; if (rcnt !== 5) begin bad++; $display("FAIL b2b_ready_count got=%0d exp=5", rcnt); end
    total++; if (misplaced !== 0) begin bad++; $display("FAIL b2b_ready_spacing got=%0d_misplaced exp=0", misplaced); end
    total++; if (idle_cnt !== 5) begin bad++; $display("FAIL b2b_idle_cycles got=%0d exp=5", idle_cnt); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int rk, rc, bc; logic ea, eb;
    int rseen = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'h55555555;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL abort_ctrl got=%b%b%b exp=000", busy, ready, err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h exp=00000000", rdata); end
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (ready !== 1'b0) rseen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (ready !== 1'b0) rseen++;
    end
    total++; if (rseen !== 0) begin bad++; $display("FAIL abort_no_ready got=%0d exp=0", rseen); end
    do_access(1'b0, 2'b00, 32'h30, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'h0 || rk !== LAT + 1) begin bad++; $display("FAIL abort_no_write got=%h/cyc%0d exp=00000000/cyc%0d", rdata, rk, LAT + 1); end
    do_access(1'b0, 2'b00, 32'h20, 32'h0, rk, rc, bc, ea, eb);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_store_cleared got=%h exp=00000000", rdata); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_partial();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle memory responder on the target side of the CPU's memory port. It accepts one request at a time (read or write; word, half or byte) and services it against an internal word-organised store after a fixed, parameterised wait. It signals completion with a one-cycle `ready` pulse. It replaces the zero-wait memory model, so the control unit's wait-for-memory states can be exercised.

## Interface
- `ADDR_W`, default 8: word-index width. The store holds 2^ADDR_W 32-bit words (1 KiB at the default).
- `LATENCY`, default 3: cycles spent in WAIT per access. Must be ≥ 1.
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous reset, active-low. 0 = reset asserted.
- `req`  in  1  request strobe. Sampled only in IDLE.
- `wr`  in  1  1 = write, 0 = read. Sampled with `req`.
- `size`  in  2  00 = word, 01 = half, 10 = byte, 11 = illegal.
- `addr`  in  32  byte address, little-endian.
- `wdata`  in  32  write data. Half uses [15:0]; byte uses [7:0].
- `rdata`  out  32  read data. Holds its value until the next successful read completes.
- `ready`  out  1  completion pulse, exactly one cycle wide.
- `busy`  out  1  high from acceptance until `ready` drops.
- `err`  out  1  alignment or size error. Valid only while `ready` is high; 0 otherwise.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If `req`=1 at an edge, latch `wr`, `size`, `addr` and `wdata` into internal registers.
  - Legal request: go to WAIT with the counter loaded to LATENCY-1.
  - Illegal request: go straight to DONE with the error flag set.
- Illegal request is any of:
  - `size`=11
  - half access with `addr[0]`=1
  - word access with `addr[1:0]`≠00
- WAIT:
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access and go to DONE.
- DONE: `ready`=1. Go to IDLE at the next edge.
- `busy`=1 in WAIT and DONE.
- `req` outside IDLE is ignored and not queued. If `req` is still high in IDLE, a new request is accepted.
- Word index is `addr[ADDR_W+1:2]`. Higher address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- Write, word: the whole word is replaced.
- Write, half: `wdata[15:0]` goes to bytes `{addr[1],1}:{addr[1],0}`.
- Write, byte: `wdata[7:0]` goes to byte lane `addr[1:0]`.
- Lanes not written are preserved.
- Reads always return the full aligned word, regardless of `size`. Lane extraction is the CPU's job.
- Write completion and error completion leave `rdata` unchanged.
- An error completion never modifies the store.

## Timing
- Reset (`reset`=0, asynchronous):
  - state IDLE, counter 0
  - `rdata`=0, `ready`=0, `busy`=0, `err`=0
  - all store words = 0
- Reset asserted mid-access aborts it. No write happens and no `ready` is generated.
- Let the request be accepted at edge E.
- Legal access:
  - The store is updated and `rdata` is loaded at edge E+LATENCY.
  - `ready`=1 from E+LATENCY to E+LATENCY+1.
  - `busy`=1 from E to E+LATENCY+1.
- Illegal access:
  - `ready`=1 and `err`=1 from E to E+1.
  - `busy`=1 for that same single cycle.
- Back-to-back with `req` held high: acceptance edges are spaced LATENCY+2 apart. A legal access occupies the bus for LATENCY+2 cycles including the IDLE cycle.
- Outputs are registered or decoded from state only. There is no combinational path from the inputs to the outputs.

## Test plan
- Release reset, then read word at 0x10 with LATENCY=3 -> `ready` is a single-cycle pulse at E+3, `rdata`=0x00000000, `err`=0, `busy` high for 4 cycles.
- Write word 0xDEADBEEF to 0x20, then read 0x20 -> `rdata`=0xDEADBEEF. Then read 0x420 -> `rdata`=0xDEADBEEF (alias at ADDR_W=8).
- Starting from 0xDEADBEEF at 0x20:
  - byte write 0x000000AA to 0x21, then read 0x20 -> 0xDEADAAEF
  - then half write 0x00001234 to 0x22, then read 0x20 -> 0x1234AAEF
- Word write to 0x23, half write to 0x21, and any access with `size`=11 -> each gives `ready`=`err`=1 one cycle after acceptance; read of 0x20 is unchanged; `rdata` keeps its previous value.
- Hold `req`=1 continuously on a read -> exactly one `ready` per LATENCY+2 cycles; no extra acceptances while `busy`=1.
- Start a write of 0x55555555 to 0x30, then assert `reset`=0 at E+1 -> all outputs 0 immediately; after release, read of 0x30 returns 0x00000000.
